gshare_branch_predictor: RTL

Parametrised global-history branch predictor for the fetch stage. It replaces the fixed 5-bit GHR / shared-index logic with a configurable design that offers:
- selectable table depth, history length and indexing mode (bimodal or gshare);
- compressed-instruction PC alignment;
- a self-initialising pattern history table (PHT);
- checkpoint-based GHR repair on mispredict;
- saturating performance counters.

Fetch performs lookups. The branch-evaluation unit in MEM performs updates.

---
 rtl/gshare_branch_predictor_pkg.sv | 40 ++++
 rtl/gshare_branch_predictor_pht_ram.sv | 37 +++
 rtl/gshare_branch_predictor.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/gshare_branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module : gshare_branch_predictor_pkg
// Brief  : Shared types, counter encodings and helpers for the gshare
//          branch predictor and its pattern history table.
// Rev    : 1.0  initial release
// ============================================================================
package gshare_branch_predictor_pkg;

    // 2-bit saturating prediction counter; MSB is the taken prediction
    typedef logic [1:0] pht_counter_t;

    typedef enum logic [0:0] {
        MODE_BIMODAL = 1'b0,
        MODE_GSHARE  = 1'b1
    } predictor_mode_e;

    typedef enum logic [0:0] {
        PRED_INIT  = 1'b0,
        PRED_READY = 1'b1
    } predictor_state_e;

    localparam pht_counter_t STRONG_NT = 2'd0;
    localparam pht_counter_t WEAK_NT   = 2'd1;
    localparam pht_counter_t WEAK_T    = 2'd2;
    localparam pht_counter_t STRONG_T  = 2'd3;

    // Move a counter one step toward the resolved outcome, clamping at the ends
    function automatic pht_counter_t sat_update(input pht_counter_t cnt, input logic taken);
        pht_counter_t result;
        if (taken) begin
            result = (cnt == STRONG_T) ? STRONG_T : cnt + 2'd1;
        end else begin
            result = (cnt == STRONG_NT) ? STRONG_NT : cnt - 2'd1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_branch_predictor_pht_ram.sv
`default_nettype none
// ============================================================================
// Module : gshare_branch_predictor_pht_ram
// Brief  : Pattern history table storage. One combinational read port and
//          one synchronous write port that either loads a value (init sweep)
//          or applies a saturating step to the addressed entry (update).
// Rev    : 1.0  initial release
// ============================================================================
module gshare_branch_predictor_pht_ram
    import gshare_branch_predictor_pkg::*;
#(
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic [INDEX_WIDTH-1:0] i_rd_addr,
    output pht_counter_t           o_rd_data,
    input  logic                   i_wr_en,
    input  logic                   i_wr_load,
    input  logic [INDEX_WIDTH-1:0] i_wr_addr,
    input  pht_counter_t           i_wr_data,
    input  logic                   i_wr_taken
);

    // The array has no reset; the init sweep gives every entry a known value
    pht_counter_t r_mem [2**INDEX_WIDTH];

    assign o_rd_data = r_mem[i_rd_addr];

    // Single write port: load during the sweep, read-modify-write on update
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_load ? i_wr_data : sat_update(r_mem[i_wr_addr], i_wr_taken);
        end
    end

endmodule
`default_nettype wire

// File: rtl/gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module : gshare_branch_predictor
// Brief  : Parametrised global-history branch predictor (bimodal or gshare
//          indexing) with self-initialising PHT, checkpoint GHR repair and
//          saturating performance counters.
// Rev    : 1.0  initial release
// ============================================================================
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int           GHR_SIZE           = 5,
    parameter int           INDEX_WIDTH        = 5,
    parameter int           MODE               = 1,
    parameter int           COMPRESSED_SUPPORT = 1,
    parameter logic [1:0]   INIT_STATE         = 2'b01,
    parameter int           STAT_WIDTH         = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   lookup_valid,
    input  logic                   lookup_is_branch,
    input  logic [31:0]            lookup_pc,
    input  logic                   stall_n,
    output logic                   predict_taken,
    output logic [GHR_SIZE-1:0]    predict_ghr,
    output logic [INDEX_WIDTH-1:0] predict_index,
    input  logic                   update_valid,
    input  logic [INDEX_WIDTH-1:0] update_index,
    input  logic [GHR_SIZE-1:0]    update_ghr,
    input  logic                   update_taken,
    input  logic                   update_mispredict,
    output logic                   busy,
    output logic [STAT_WIDTH-1:0]  branch_count,
    output logic [STAT_WIDTH-1:0]  mispredict_count
);

    localparam int              c_pc_lsb = (COMPRESSED_SUPPORT != 0) ? 1 : 2;
    localparam predictor_mode_e c_mode   = (MODE != 0) ? MODE_GSHARE : MODE_BIMODAL;

    predictor_state_e       r_state;
    predictor_state_e       w_state_next;
    logic [INDEX_WIDTH-1:0] r_init_ptr;
    logic [GHR_SIZE-1:0]    r_ghr;
    logic [GHR_SIZE-1:0]    w_spec_ghr;
    logic [GHR_SIZE-1:0]    w_repair_ghr;
    logic [INDEX_WIDTH-1:0] w_pc_bits;
    logic [INDEX_WIDTH-1:0] w_ghr_ext;
    logic [INDEX_WIDTH-1:0] w_index;
    pht_counter_t           w_rd_counter;
    logic                   w_busy;
    logic                   w_ready;
    logic                   w_predict_taken;
    logic                   w_spec_shift;
    logic                   w_repair;
    logic                   w_pht_we;
    logic [INDEX_WIDTH-1:0] w_pht_waddr;
    logic [STAT_WIDTH-1:0]  r_branch_count;
    logic [STAT_WIDTH-1:0]  r_mispredict_count;
    logic                   w_unused;

    assign w_busy  = (r_state == PRED_INIT);
    assign w_ready = (r_state == PRED_READY);

    // PC bits above the instruction-alignment granule
    assign w_pc_bits = lookup_pc[INDEX_WIDTH-1+c_pc_lsb : c_pc_lsb];

    // Fit the history to the index width: truncate long histories, zero-extend short ones
    if (GHR_SIZE >= INDEX_WIDTH) begin : g_ghr_trunc
        assign w_ghr_ext = r_ghr[INDEX_WIDTH-1:0];
    end else begin : g_ghr_zext
        assign w_ghr_ext = {{(INDEX_WIDTH-GHR_SIZE){1'b0}}, r_ghr};
    end

    if (c_mode == MODE_GSHARE) begin : g_idx_gshare
        assign w_index = w_pc_bits ^ w_ghr_ext;
    end else begin : g_idx_bimodal
        assign w_index = w_pc_bits;
    end

    // Next history values for a speculative shift and for a checkpoint repair
    if (GHR_SIZE == 1) begin : g_ghr_single
        assign w_spec_ghr   = w_predict_taken;
        assign w_repair_ghr = update_taken;
    end else begin : g_ghr_multi
        assign w_spec_ghr   = {r_ghr[GHR_SIZE-2:0], w_predict_taken};
        assign w_repair_ghr = {update_ghr[GHR_SIZE-2:0], update_taken};
    end

    assign w_predict_taken = w_busy ? 1'b0 : w_rd_counter[1];
    assign w_spec_shift    = w_ready & lookup_valid & lookup_is_branch & stall_n;
    assign w_repair        = w_ready & update_valid & update_mispredict;

    // Init sweep owns the write port while busy; resolved updates use it afterwards
    assign w_pht_we    = w_busy | (w_ready & update_valid);
    assign w_pht_waddr = w_busy ? r_init_ptr : update_index;

    gshare_branch_predictor_pht_ram #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_pht_ram (
        .clk        (clk),
        .i_rd_addr  (w_index),
        .o_rd_data  (w_rd_counter),
        .i_wr_en    (w_pht_we),
        .i_wr_load  (w_busy),
        .i_wr_addr  (w_pht_waddr),
        .i_wr_data  (INIT_STATE),
        .i_wr_taken (update_taken)
    );

    // Next-state logic: leave INIT once the last entry has been written
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PRED_INIT:  if (r_init_ptr == {INDEX_WIDTH{1'b1}}) w_state_next = PRED_READY;
            PRED_READY: w_state_next = PRED_READY;
            default:    w_state_next = PRED_INIT;
        endcase
    end

    // State register and sweep pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= PRED_INIT;
            r_init_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_busy) begin
                r_init_ptr <= r_init_ptr + INDEX_WIDTH'(1);
            end
        end
    end

    // Global history: checkpoint repair overrides a same-cycle speculative shift
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ghr <= '0;
        end else if (w_repair) begin
            r_ghr <= w_repair_ghr;
        end else if (w_spec_shift) begin
            r_ghr <= w_spec_ghr;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_ready && update_valid) begin
            if (r_branch_count != {STAT_WIDTH{1'b1}}) begin
                r_branch_count <= r_branch_count + STAT_WIDTH'(1);
            end
            if (update_mispredict && (r_mispredict_count != {STAT_WIDTH{1'b1}})) begin
                r_mispredict_count <= r_mispredict_count + STAT_WIDTH'(1);
            end
        end
    end

    assign predict_taken    = w_predict_taken;
    assign predict_ghr      = r_ghr;
    assign predict_index    = w_index;
    assign busy             = w_busy;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

    // Bits not needed for indexing or repair at this configuration
    assign w_unused = ^{lookup_pc, update_ghr, w_rd_counter[0]};

endmodule
`default_nettype wire
